// File: rtl/wbu.sv
// wbu - writeback unit.
// Takes retiring instructions from the EXU and drives the register-file
// write port with a one-cycle registered pulse per retirement. ALU results
// retire on the next edge. Loads park in WAIT_LOAD until the LSU returns
// the word, which is then aligned and extended.
//
// State table:
//   IDLE      | ready for EXU; ALU ops retire next edge, loads are captured
//   WAIT_LOAD | load outstanding; EXU stalled, waiting for lsu_rvalid_i
//
// Ports:
//   clk_i, rst_i                  clock, async active-low reset
//   exu_valid_i / exu_ready_o     EXU retire handshake
//   exu_wen_i, exu_rd_i           destination write enable / index
//   exu_is_load_i, exu_funct3_i,
//   exu_addr_lo_i                 load descriptor
//   exu_result_i                  ALU result for non-loads
//   lsu_rvalid_i / lsu_rready_o   LSU read-data handshake
//   lsu_rdata_i                   aligned memory word
//   wen_o, rd_o, wdata_o          register-file write port
//   commit_o                      one pulse per retired instruction
//   busy_o                        load outstanding
//   instret_o                     retired-instruction counter (wraps)
module wbu #(
  parameter int XLEN = 32,
  parameter int RS_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            exu_valid_i,
  output logic            exu_ready_o,
  input  logic            exu_wen_i,
  input  logic [RS_W-1:0] exu_rd_i,
  input  logic            exu_is_load_i,
  input  logic [2:0]      exu_funct3_i,
  input  logic [1:0]      exu_addr_lo_i,
  input  logic [XLEN-1:0] exu_result_i,
  input  logic            lsu_rvalid_i,
  input  logic [XLEN-1:0] lsu_rdata_i,
  output logic            lsu_rready_o,
  output logic            wen_o,
  output logic [RS_W-1:0] rd_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            commit_o,
  output logic            busy_o,
  output logic [31:0]     instret_o
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              wen_q, wen_d;
  logic [RS_W-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              commit_q, commit_d;
  logic [31:0]       instret_q, instret_d;
  logic              ld_wen_q, ld_wen_d;
  logic [RS_W-1:0]   ld_rd_q, ld_rd_d;
  logic [2:0]        ld_funct3_q, ld_funct3_d;
  logic [1:0]        ld_addr_q, ld_addr_d;
  logic [XLEN-1:0]   load_data;

  // Byte lane selected by both address bits; halfword lane only by bit 1.
  logic [XLEN-1:0] byte_shift;
  logic [XLEN-1:0] half_shift;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  always_comb begin
    byte_shift = lsu_rdata_i >> {ld_addr_q, 3'b000};
    half_shift = lsu_rdata_i >> {ld_addr_q[1], 4'b0000};
    ld_byte    = byte_shift[7:0];
    ld_half    = half_shift[15:0];
    case (ld_funct3_q)
      3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
      default: load_data = lsu_rdata_i;   // LW and unused encodings
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wen_d       = 1'b0;
    commit_d    = 1'b0;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    instret_d   = instret_q;
    ld_wen_d    = ld_wen_q;
    ld_rd_d     = ld_rd_q;
    ld_funct3_d = ld_funct3_q;
    ld_addr_d   = ld_addr_q;
    exu_ready_o  = 1'b0;
    lsu_rready_o = 1'b0;
    busy_o       = 1'b0;

    unique case (state_q)
      IDLE: begin
        exu_ready_o = 1'b1;
        if (exu_valid_i) begin
          if (exu_is_load_i) begin
            ld_wen_d    = exu_wen_i;
            ld_rd_d     = exu_rd_i;
            ld_funct3_d = exu_funct3_i;
            ld_addr_d   = exu_addr_lo_i;
            state_d     = WAIT_LOAD;
          end else begin
            wen_d     = exu_wen_i && (exu_rd_i != '0);
            rd_d      = exu_rd_i;
            wdata_d   = exu_result_i;
            commit_d  = 1'b1;
            instret_d = instret_q + 32'd1;
          end
        end
      end
      WAIT_LOAD: begin
        lsu_rready_o = 1'b1;
        busy_o       = 1'b1;
        if (lsu_rvalid_i) begin
          wen_d     = ld_wen_q && (ld_rd_q != '0);
          rd_d      = ld_rd_q;
          wdata_d   = load_data;
          commit_d  = 1'b1;
          instret_d = instret_q + 32'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      wen_q       <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
      commit_q    <= 1'b0;
      instret_q   <= '0;
      ld_wen_q    <= 1'b0;
      ld_rd_q     <= '0;
      ld_funct3_q <= '0;
      ld_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      wen_q       <= wen_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      commit_q    <= commit_d;
      instret_q   <= instret_d;
      ld_wen_q    <= ld_wen_d;
      ld_rd_q     <= ld_rd_d;
      ld_funct3_q <= ld_funct3_d;
      ld_addr_q   <= ld_addr_d;
    end
  end

  assign wen_o     = wen_q;
  assign rd_o      = rd_q;
  assign wdata_o   = wdata_q;
  assign commit_o  = commit_q;
  assign instret_o = instret_q;

endmodule

// File: tb/tb_wbu.sv
module tb_wbu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        exu_valid_i;
  logic        exu_ready_o;
  logic        exu_wen_i;
  logic [4:0]  exu_rd_i;
  logic        exu_is_load_i;
  logic [2:0]  exu_funct3_i;
  logic [1:0]  exu_addr_lo_i;
  logic [31:0] exu_result_i;
  logic        lsu_rvalid_i;
  logic [31:0] lsu_rdata_i;
  logic        lsu_rready_o;
  logic        wen_o;
  logic [4:0]  rd_o;
  logic [31:0] wdata_o;
  logic        commit_o;
  logic        busy_o;
  logic [31:0] instret_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_instret = 0;

  wbu #(.XLEN(32), .RS_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .exu_valid_i(exu_valid_i), .exu_ready_o(exu_ready_o),
    .exu_wen_i(exu_wen_i), .exu_rd_i(exu_rd_i),
    .exu_is_load_i(exu_is_load_i), .exu_funct3_i(exu_funct3_i),
    .exu_addr_lo_i(exu_addr_lo_i), .exu_result_i(exu_result_i),
    .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i),
    .lsu_rready_o(lsu_rready_o),
    .wen_o(wen_o), .rd_o(rd_o), .wdata_o(wdata_o),
    .commit_o(commit_o), .busy_o(busy_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_load;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] rdata;
    logic        exp_wen;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk_i);
    exu_valid_i   = 1'b1;
    exu_is_load_i = v.is_load;
    exu_funct3_i  = v.funct3;
    exu_addr_lo_i = v.addr_lo;
    exu_wen_i     = v.wen;
    exu_rd_i      = v.rd;
    exu_result_i  = v.result;
    step();
    exu_valid_i = 1'b0;
    if (v.is_load) begin
      chk({tag, "_ld_busy"}, {31'd0, busy_o}, 32'd1);
      chk({tag, "_ld_nocommit"}, {31'd0, commit_o}, 32'd0);
      lsu_rvalid_i = 1'b1;
      lsu_rdata_i  = v.rdata;
      step();
      lsu_rvalid_i = 1'b0;
    end
    exp_instret++;
    chk({tag, "_wen"}, {31'd0, wen_o}, {31'd0, v.exp_wen});
    chk({tag, "_rd"}, {27'd0, rd_o}, {27'd0, v.rd});
    chk({tag, "_wdata"}, wdata_o, v.exp_wdata);
    chk({tag, "_commit"}, {31'd0, commit_o}, 32'd1);
    chk({tag, "_instret"}, instret_o, exp_instret);
    step();
    chk({tag, "_wen_pulse"}, {31'd0, wen_o}, 32'd0);
    chk({tag, "_commit_pulse"}, {31'd0, commit_o}, 32'd0);
    chk({tag, "_wdata_hold"}, wdata_o, v.exp_wdata);
  endtask

  initial begin
    //          load funct3  addr wen rd     result        rdata         ewen  ewdata
    vecs[0]  = '{1'b0, 3'b000, 2'd0, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b000, 2'd0, 1'b1, 5'd0,  32'h12345678, 32'h0,        1'b0, 32'h12345678};
    vecs[2]  = '{1'b0, 3'b000, 2'd0, 1'b0, 5'd3,  32'hA5A5A5A5, 32'h0,        1'b0, 32'hA5A5A5A5};
    vecs[3]  = '{1'b1, 3'b000, 2'd3, 1'b1, 5'd6,  32'h0,        32'h80AABBCC, 1'b1, 32'hFFFFFF80};
    vecs[4]  = '{1'b1, 3'b100, 2'd3, 1'b1, 5'd7,  32'h0,        32'h80AABBCC, 1'b1, 32'h00000080};
    vecs[5]  = '{1'b1, 3'b000, 2'd0, 1'b1, 5'd8,  32'h0,        32'h80AABBCC, 1'b1, 32'hFFFFFFCC};
    vecs[6]  = '{1'b1, 3'b100, 2'd1, 1'b1, 5'd9,  32'h0,        32'h80AABBCC, 1'b1, 32'h000000BB};
    vecs[7]  = '{1'b1, 3'b001, 2'd2, 1'b1, 5'd10, 32'h0,        32'h80011234, 1'b1, 32'hFFFF8001};
    vecs[8]  = '{1'b1, 3'b101, 2'd2, 1'b1, 5'd11, 32'h0,        32'h80011234, 1'b1, 32'h00008001};
    vecs[9]  = '{1'b1, 3'b001, 2'd0, 1'b1, 5'd12, 32'h0,        32'h80011234, 1'b1, 32'h00001234};
    vecs[10] = '{1'b1, 3'b001, 2'd3, 1'b1, 5'd13, 32'h0,        32'h80011234, 1'b1, 32'hFFFF8001};
    vecs[11] = '{1'b1, 3'b010, 2'd1, 1'b1, 5'd14, 32'h0,        32'h80011234, 1'b1, 32'h80011234};
    vecs[12] = '{1'b1, 3'b011, 2'd2, 1'b1, 5'd15, 32'h0,        32'h80011234, 1'b1, 32'h80011234};
    vecs[13] = '{1'b1, 3'b110, 2'd3, 1'b1, 5'd16, 32'h0,        32'h80011234, 1'b1, 32'h80011234};
    vecs[14] = '{1'b1, 3'b000, 2'd0, 1'b1, 5'd0,  32'h0,        32'h80AABBCC, 1'b0, 32'hFFFFFFCC};
    vecs[15] = '{1'b1, 3'b001, 2'd0, 1'b1, 5'd17, 32'h0,        32'h0000F00F, 1'b1, 32'hFFFFF00F};

    rst_i = 1'b0;
    exu_valid_i = 1'b0; exu_wen_i = 1'b0; exu_rd_i = '0; exu_is_load_i = 1'b0;
    exu_funct3_i = '0; exu_addr_lo_i = '0; exu_result_i = '0;
    lsu_rvalid_i = 1'b0; lsu_rdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_wen", {31'd0, wen_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_instret", instret_o, 32'd0);
    chk("rst_ready", {31'd0, exu_ready_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_rready", {31'd0, lsu_rready_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // lsu_rvalid_i in IDLE must be ignored
    @(negedge clk_i);
    lsu_rvalid_i = 1'b1;
    lsu_rdata_i  = 32'h55555555;
    step();
    lsu_rvalid_i = 1'b0;
    chk("idle_rvalid_commit", {31'd0, commit_o}, 32'd0);
    chk("idle_rvalid_busy", {31'd0, busy_o}, 32'd0);
    chk("idle_rvalid_instret", instret_o, exp_instret);

    // Back-pressure: load outstanding while an ALU op is held valid
    @(negedge clk_i);
    exu_valid_i = 1'b1; exu_is_load_i = 1'b1; exu_funct3_i = 3'b010;
    exu_addr_lo_i = 2'd0; exu_wen_i = 1'b1; exu_rd_i = 5'd9;
    step();
    exu_is_load_i = 1'b0; exu_rd_i = 5'd10; exu_result_i = 32'h00000011;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_ready_c%0d", i), {31'd0, exu_ready_o}, 32'd0);
      chk($sformatf("bp_busy_c%0d", i), {31'd0, busy_o}, 32'd1);
      chk($sformatf("bp_nowen_c%0d", i), {30'd0, wen_o, commit_o}, 32'd0);
      step();
    end
    lsu_rvalid_i = 1'b1;
    lsu_rdata_i  = 32'hCAFEF00D;
    step();
    lsu_rvalid_i = 1'b0;
    chk("bp_ld_wen", {31'd0, wen_o}, 32'd1);
    chk("bp_ld_rd", {27'd0, rd_o}, 32'd9);
    chk("bp_ld_wdata", wdata_o, 32'hCAFEF00D);
    chk("bp_ld_ready", {31'd0, exu_ready_o}, 32'd1);
    step();
    exu_valid_i = 1'b0;
    chk("bp_alu_wen", {31'd0, wen_o}, 32'd1);
    chk("bp_alu_rd", {27'd0, rd_o}, 32'd10);
    chk("bp_alu_wdata", wdata_o, 32'h00000011);
    exp_instret += 2;
    chk("bp_instret", instret_o, exp_instret);
    step();
    chk("bp_idle_commit", {31'd0, commit_o}, 32'd0);

    // Reset while a load is outstanding
    @(negedge clk_i);
    exu_valid_i = 1'b1; exu_is_load_i = 1'b1; exu_funct3_i = 3'b010;
    exu_wen_i = 1'b1; exu_rd_i = 5'd7;
    step();
    exu_valid_i = 1'b0; exu_is_load_i = 1'b0;
    chk("rml_busy_before", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b0;
    #2;
    chk("rml_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rml_rst_ready", {31'd0, exu_ready_o}, 32'd1);
    chk("rml_rst_outs", {26'd0, wen_o, rd_o}, 32'd0);
    chk("rml_rst_wdata", wdata_o, 32'd0);
    chk("rml_rst_instret", instret_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    lsu_rvalid_i = 1'b1;
    lsu_rdata_i  = 32'h77777777;
    step();
    lsu_rvalid_i = 1'b0;
    chk("rml_post_wen", {31'd0, wen_o}, 32'd0);
    chk("rml_post_commit", {31'd0, commit_o}, 32'd0);
    chk("rml_post_rd", {27'd0, rd_o}, 32'd0);
    chk("rml_post_instret", instret_o, 32'd0);
    chk("rml_post_ready", {31'd0, exu_ready_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wbu.md
Name: wbu

Overview:
Writeback unit; the write-side counterpart of the register file's read ports.
- Accepts retiring instructions from the EXU (ALU result, or a load descriptor).
- For loads, waits for LSU read data, then aligns and extends it.
- Drives the single register-file write port (wen/rd/wdata) with a registered, one-cycle write pulse per retired instruction.
- Counts retired instructions.

Parameters:
XLEN, 32, register/data width
RS_W, 5, register index width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
exu_valid_i  input  1  EXU presents a retiring instruction
exu_ready_o  output  1  WBU can accept from EXU
exu_wen_i  input  1  instruction writes rd
exu_rd_i  input  RS_W  destination register
exu_is_load_i  input  1  instruction is a load; result comes from LSU
exu_funct3_i  input  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
exu_addr_lo_i  input  2  load address bits [1:0]
exu_result_i  input  XLEN  ALU result (non-load)
lsu_rvalid_i  input  1  LSU read data valid
lsu_rdata_i  input  XLEN  aligned 32-bit word from memory
lsu_rready_o  output  1  WBU accepts LSU data
wen_o  output  1  register-file write enable (one-cycle pulse)
rd_o  output  RS_W  write index
wdata_o  output  XLEN  write data
commit_o  output  1  one-cycle pulse per retired instruction
busy_o  output  1  load outstanding
instret_o  output  32  retired-instruction count

Behaviour:
- Reset (rst_i low, async): state IDLE; wen_o=0, rd_o=0, wdata_o=0, commit_o=0, instret_o=0, pending-load registers cleared. Combinational outputs follow state: exu_ready_o=1, lsu_rready_o=0, busy_o=0.
- FSM states:
  - IDLE: exu_ready_o=1, lsu_rready_o=0, busy_o=0.
  - WAIT_LOAD: exu_ready_o=0, lsu_rready_o=1, busy_o=1.
- IDLE with exu_valid_i && !exu_is_load_i:
  - Next edge: wen_o = exu_wen_i && (exu_rd_i != 0); rd_o = exu_rd_i; wdata_o = exu_result_i; commit_o=1; instret_o+1.
  - Stay IDLE. Back-to-back ALU retirements are accepted every cycle.
- IDLE with exu_valid_i && exu_is_load_i:
  - Capture wen, rd, funct3 and addr_lo; go to WAIT_LOAD.
  - No write and no commit that cycle.
- WAIT_LOAD with lsu_rvalid_i:
  - Next edge: write the extracted data, commit_o=1, instret_o+1, return to IDLE.
  - Earliest new EXU accept is the cycle after the write.
- Load extraction:
  - byte = rdata >> (addr_lo*8), low 8 bits; half = rdata >> (addr_lo[1]*16), low 16 bits. addr_lo[0] is ignored for halfwords.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word and ignores addr_lo.
  - funct3 011/110/111 are treated as LW.
- wen_o, commit_o: single-cycle pulses. In every cycle without a retirement they are 0; rd_o and wdata_o hold their last values.
- Writes to x0: wen_o forced 0; commit_o still pulses.
- Ignored inputs:
  - lsu_rvalid_i in IDLE.
  - exu_valid_i in WAIT_LOAD (EXU must hold its instruction).
- instret_o wraps 0xFFFFFFFF -> 0 without a flag.
- Reset mid-WAIT_LOAD: the pending load is dropped with no write. LSU data arriving after reset release is ignored (state is IDLE).

Test Plan:
1. ALU writeback: exu_valid_i=1, is_load=0, wen=1, rd=5, result=0xDEADBEEF -> next cycle wen_o=1, rd_o=5, wdata_o=0xDEADBEEF, commit_o=1, instret_o=1; following cycle wen_o=0.
2. x0 suppression: rd=0, wen=1, result=0x12345678 -> wen_o=0, commit_o=1, instret_o increments.
3. Byte loads, rdata=0x80AABBCC, addr_lo=3:
   - LB -> wdata_o=0xFFFFFF80.
   - LBU -> 0x00000080.
   - LB addr_lo=0 -> 0xFFFFFFCC.
4. Halfword/word loads, rdata=0x80011234:
   - LH addr_lo=2 -> 0xFFFF8001.
   - LHU addr_lo=2 -> 0x00008001.
   - LH addr_lo=0 -> 0x00001234.
   - LW -> 0x80011234.
5. Back-pressure: load accepted, then an ALU op held valid while lsu_rvalid_i stays low for 4 cycles:
   - exu_ready_o=0 and busy_o=1 for all 4 cycles.
   - rvalid -> load written next cycle; ALU op accepted that cycle and written the cycle after.
   - instret_o +2 total.
6. Reset mid-load: load to rd=7 accepted, rst_i pulsed low in WAIT_LOAD, then lsu_rvalid_i=1 after release -> no write to rd=7, all outputs 0, instret_o=0, exu_ready_o=1.
